// File: rtl/jtdd_rom_arbiter.sv
// Multi-slot SDRAM ROM arbiter: one 32-bit cached line per slot, misses served one at a time.
// Define JTDD_ROMARB_RR_EN for round-robin arbitration; otherwise fixed priority, slot 0 highest.
module jtdd_rom_arbiter #(
    parameter int unsigned         SLOTS   = 4,
    parameter int unsigned         AW      = 18,
    parameter int unsigned         DW      = 8,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic [21:0]           sdram_addr,
    input  logic [31:0]           data_read,
    input  logic                  data_dst,
    input  logic                  data_rdy
);
    localparam int unsigned SW = (DW == 8) ? 2 : 1;
    localparam int unsigned TW = AW - SW;
    localparam int unsigned GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e           state_q, state_d;
    logic [31:0]      line_q [SLOTS];
    logic [TW-1:0]    tag_q  [SLOTS];
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [GW-1:0]    gnt_q, gnt_d;
    logic [TW-1:0]    ltag_q, ltag_d;
    logic [21:0]      addr_q, addr_d;
    logic             fill;

    logic [TW-1:0]    req_tag  [SLOTS];
    logic [21:0]      req_addr [SLOTS];
    logic [SLOTS-1:0] hit, pending;
    logic [GW-1:0]    sel;
    logic             sel_vld;
    logic             unused_dst;

    assign unused_dst = data_dst;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [AW-1:0] a;
        logic [SW-1:0] part;
        logic [4:0]    bit_off;
        assign a           = slot_addr[i*AW +: AW];
        assign part        = a[SW-1:0];
        assign bit_off     = 5'(part) << $clog2(DW);
        assign req_tag[i]  = a[AW-1:SW];
        assign req_addr[i] = OFFSETS[i*22 +: 22] + 22'({req_tag[i], 1'b0});
        assign hit[i]      = valid_q[i] && (tag_q[i] == req_tag[i]);
        assign slot_ok[i]  = slot_cs[i] & hit[i];
        assign pending[i]  = slot_cs[i] & ~hit[i];
        assign slot_dout[i*DW +: DW] = line_q[i][bit_off +: DW];
    end

`ifdef JTDD_ROMARB_RR_EN
    logic [GW-1:0] ptr_q;
    int            rr_idx;

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        rr_idx  = 0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= int'(SLOTS)) rr_idx = rr_idx - int'(SLOTS);
            if (!sel_vld && pending[rr_idx]) begin
                sel     = GW'(rr_idx);
                sel_vld = 1'b1;
            end
        end
    end

    // Pointer moves only on an issued grant, to the slot after it
    always_ff @(posedge clk) begin
        if (!rstb) begin
            ptr_q <= '0;
        end else if (state_q == StIdle && sel_vld && !downloading) begin
            ptr_q <= (int'(sel) == int'(SLOTS) - 1) ? '0 : sel + 1'b1;
        end
    end
`else
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = int'(SLOTS) - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel     = GW'(k);
                sel_vld = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StIdle;
            valid_q <= '0;
            gnt_q   <= '0;
            ltag_q  <= '0;
            addr_q  <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                line_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            ltag_q  <= ltag_d;
            addr_q  <= addr_d;
            if (fill) begin
                line_q[gnt_q] <= data_read;
                tag_q[gnt_q]  <= ltag_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        ltag_d  = ltag_q;
        addr_d  = addr_q;
        fill    = 1'b0;
        if (downloading) begin
            state_d = StIdle;
            valid_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_vld) begin
                        gnt_d   = sel;
                        ltag_d  = req_tag[sel];
                        addr_d  = req_addr[sel];
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (sdram_ack) state_d = StWait;
                end
                StWait: begin
                    // Fill with the latched tag even if the slot address moved meanwhile
                    if (data_rdy) begin
                        fill           = 1'b1;
                        valid_d[gnt_q] = 1'b1;
                        state_d        = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sdram_req  = (state_q == StReq);
        sdram_addr = addr_q;
    end

endmodule

// File: tb/tb_jtdd_rom_arbiter.sv
// Directed bench for jtdd_rom_arbiter: a DW=8 four-slot instance and a DW=16 two-slot instance.
module tb_jtdd_rom_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, downloading;
    logic [3:0]  cs;
    logic [71:0] addr;
    logic [3:0]  ok;
    logic [31:0] dout;
    logic        req, ack, dst, rdy;
    logic [21:0] saddr;
    logic [31:0] rdata;

    logic [1:0]  cs16;
    logic [33:0] addr16;
    logic [1:0]  ok16;
    logic [31:0] dout16;
    logic        req16, ack16, rdy16;
    logic [21:0] saddr16;
    logic [31:0] rdata16;

    int n_checks = 0;
    int n_errors = 0;

    jtdd_rom_arbiter #(
        .SLOTS(4), .AW(18), .DW(8),
        .OFFSETS({22'h0, 22'h0, 22'h10000, 22'h28000})
    ) u_dut8 (
        .clk(clk), .rstb(rstb), .downloading(downloading),
        .slot_cs(cs), .slot_addr(addr), .slot_ok(ok), .slot_dout(dout),
        .sdram_req(req), .sdram_ack(ack), .sdram_addr(saddr),
        .data_read(rdata), .data_dst(dst), .data_rdy(rdy)
    );

    jtdd_rom_arbiter #(
        .SLOTS(2), .AW(17), .DW(16),
        .OFFSETS({22'h60000, 22'h0})
    ) u_dut16 (
        .clk(clk), .rstb(rstb), .downloading(downloading),
        .slot_cs(cs16), .slot_addr(addr16), .slot_ok(ok16), .slot_dout(dout16),
        .sdram_req(req16), .sdram_ack(ack16), .sdram_addr(saddr16),
        .data_read(rdata16), .data_dst(dst), .data_rdy(rdy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [21:0] first_addr, second_addr;
    logic [3:0]  first_ok;

    initial begin
        rstb = 1'b0; downloading = 1'b0; cs = '0; addr = '0; ack = 1'b0;
        dst = 1'b0; rdy = 1'b0; rdata = '0;
        cs16 = '0; addr16 = '0; ack16 = 1'b0; rdy16 = 1'b0; rdata16 = '0;
        step();
        step();
        check("rst_req", req, 0);
        check("rst_addr", saddr, 0);
        check("rst_ok", ok, 0);
        check("rst_dout", dout, 0);
        rstb = 1'b1;

        // First miss on slot 0, then a long-held request
        cs[0] = 1'b1; addr[17:0] = 18'h00005;
        #1 check("miss_ok", ok[0], 0);
        step();
        check("miss_req", req, 1);
        check("miss_addr", saddr, 22'h28002);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_req_addr", {req, saddr}, {1'b1, 22'h28002});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ack_drop", req, 0);
        rdata = 32'hDDCCBBAA; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("fill_ok", ok[0], 1);
        check("fill_dout", dout[7:0], 8'hBB);
        addr[17:0] = 18'h00006;
        #1 check("hit_dout", dout[7:0], 8'hCC);
        check("hit_ok", ok[0], 1);
        step();
        check("hit_noreq", req, 0);

        // Slots 0 and 1 miss together
`ifdef JTDD_ROMARB_RR_EN
        first_addr = 22'h10002; second_addr = 22'h28008; first_ok = 4'b0010;
`else
        first_addr = 22'h28008; second_addr = 22'h10002; first_ok = 4'b0001;
`endif
        addr[17:0] = 18'h00010; cs[1] = 1'b1; addr[35:18] = 18'h00004;
        step();
        check("arb1_addr", saddr, first_addr);
        ack = 1'b1;
        step();
        ack = 1'b0;
        rdata = 32'h11223344; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("arb1_ok", ok, first_ok);
        check("arb_idle_gap", req, 0);
        step();
        check("arb2_req", req, 1);
        check("arb2_addr", saddr, second_addr);
        ack = 1'b1;
        step();
        ack = 1'b0;
        rdata = 32'h55667788; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("arb2_ok", ok, 4'b0011);
        check("arb_dout", dout[15:0], (first_ok == 4'b0001) ? 16'h8844 : 16'h4488);

        // Address moves while the fetch is outstanding
        cs[1] = 1'b0; addr[17:0] = 18'h00020;
        step();
        check("mv_addr", saddr, 22'h28010);
        ack = 1'b1;
        step();
        ack = 1'b0;
        addr[17:0] = 18'h00100;
        rdata = 32'hA1A2A3A4; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("mv_ok", ok[0], 0);
        check("mv_idle", req, 0);
        step();
        check("mv_req2", {req, saddr}, {1'b1, 22'h28080});
        addr[17:0] = 18'h00020;
        #1 check("mv_oldtag", {ok[0], dout[7:0]}, {1'b1, 8'hA4});
        cs[0] = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        rdata = 32'h0; rdy = 1'b1;
        step();
        rdy = 1'b0;

        // Download starts with a request outstanding
        cs[0] = 1'b1; addr[17:0] = 18'h00040; cs[1] = 1'b1;
        step();
        check("dl_req", {req, saddr}, {1'b1, 22'h28020});
        check("dl_ok_before", ok, 4'b0010);
        downloading = 1'b1;
        step();
        check("dl_req_off", req, 0);
        check("dl_ok_off", ok, 0);
        rdata = 32'hFFFFFFFF; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("dl_still_off", {req, ok}, 5'b0);
        cs[1] = 1'b0;
        downloading = 1'b0;
        #1 check("dl_rdy_ignored", dout[7:0], 8'h00);
        step();
        check("dl_reissue", {req, saddr}, {1'b1, 22'h28020});
        ack = 1'b1;
        step();
        ack = 1'b0;
        rdata = 32'h000000F0; rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("dl_fill", {ok[0], dout[7:0]}, {1'b1, 8'hF0});

        // 16-bit instance, slot 1
        cs16 = 2'b10; addr16[33:17] = 17'h00003;
        step();
        check("w16_req", {req16, saddr16}, {1'b1, 22'h60002});
        ack16 = 1'b1;
        step();
        ack16 = 1'b0;
        rdata16 = 32'h56781234; rdy16 = 1'b1;
        step();
        rdy16 = 1'b0;
        check("w16_ok", ok16, 2'b10);
        check("w16_dout", dout16[31:16], 16'h5678);
        addr16[33:17] = 17'h00002;
        #1 check("w16_dout_lo", dout16[31:16], 16'h1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
